stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 42 ++++
 rtl/seg7_scan.sv | 46 ++++
 rtl/stopwatch_core.sv | 117 +++++++++++
 tb/tb_stopwatch_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: adjust-mode encoding and the
// BCD to active-low seven-segment decode used by the display scanner.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ADJ_NORMAL = 2'b00,
        ADJ_MIN    = 2'b01,
        ADJ_SEC    = 2'b10
    } adj_mode_e;

    // Segment order is seg[6]=a .. seg[0]=g, driven low to light a segment.
    // Anything that is not a decimal digit is shown blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h01;
            4'd1:    seg = 7'h4F;
            4'd2:    seg = 7'h12;
            4'd3:    seg = 7'h06;
            4'd4:    seg = 7'h4C;
            4'd5:    seg = 7'h24;
            4'd6:    seg = 7'h20;
            4'd7:    seg = 7'h0F;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h04;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Two-digit BCD increment without any wrap limit; callers handle wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver. A 2-bit scan index steps on
// tick_scan; the digit enable and segment pattern are registered so the
// display pins only change on a clock edge.
module seg7_scan
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_scan,
    input  logic [15:0] digits,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    logic [1:0] scan_idx;
    logic [1:0] scan_next;
    logic [3:0] digit_sel;

    // Next scan position and the digit it selects.
    always_comb begin
        scan_next = scan_idx + {1'b0, tick_scan};
        digit_sel = 4'd0;
        case (scan_next)
            2'd0: digit_sel = digits[3:0];
            2'd1: digit_sel = digits[7:4];
            2'd2: digit_sel = digits[11:8];
            2'd3: digit_sel = digits[15:12];
            default: digit_sel = 4'd0;
        endcase
    end

    // Register scan index and drive the pins; blanking forces enables high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx <= 2'd0;
            an       <= 4'b1110;
            seg      <= bcd_to_seg(4'd0);
        end else begin
            scan_idx <= scan_next;
            an       <= ~(4'b0001 << scan_next) | blank;
            seg      <= bcd_to_seg(digit_sel);
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch held directly in BCD, with pause toggle, field adjust
// modes with blinking of the field being adjusted, and a scanned display.
//
//   mode        | meaning
//   ADJ_NORMAL  | tick_sec counts time when not paused (adj_mode 00 or 11)
//   ADJ_MIN     | tick_adj steps minutes, seconds hold, minutes blink
//   ADJ_SEC     | tick_adj steps seconds without carry, seconds blink
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_sec,
    input  logic       tick_adj,
    input  logic       tick_blink,
    input  logic       tick_scan,
    input  logic       pause_pulse,
    input  logic [1:0] adj_mode,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       paused,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    adj_mode_e  mode;
    logic       blink_phase;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;
    logic       sec_wrap;
    logic [3:0] blank;

    // Reserved encoding 11 behaves as normal counting.
    always_comb begin
        case (adj_mode)
            2'b01:   mode = ADJ_MIN;
            2'b10:   mode = ADJ_SEC;
            default: mode = ADJ_NORMAL;
        endcase
    end

    // Wrapped increments of each field and the seconds carry condition.
    always_comb begin
        sec_wrap = (sec_bcd == 8'h59);
        sec_inc  = sec_wrap ? 8'h00 : bcd_inc(sec_bcd);
        min_inc  = (min_bcd == MAX_MIN_BCD) ? 8'h00 : bcd_inc(min_bcd);
    end

    // Time, pause and blink state; a tick coincident with a pause press
    // sees the pause value from before the toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_bcd     <= 8'h00;
            sec_bcd     <= 8'h00;
            paused      <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            if (pause_pulse) begin
                paused <= ~paused;
            end
            case (mode)
                ADJ_MIN: begin
                    if (tick_adj) begin
                        min_bcd <= min_inc;
                    end
                    if (tick_blink) begin
                        blink_phase <= ~blink_phase;
                    end
                end
                ADJ_SEC: begin
                    if (tick_adj) begin
                        sec_bcd <= sec_inc;
                    end
                    if (tick_blink) begin
                        blink_phase <= ~blink_phase;
                    end
                end
                default: begin
                    blink_phase <= 1'b0;
                    if (tick_sec && !paused) begin
                        sec_bcd <= sec_inc;
                        if (sec_wrap) begin
                            min_bcd <= min_inc;
                        end
                    end
                end
            endcase
        end
    end

    // Hide the field under adjustment during the blink-on phase.
    always_comb begin
        blank = 4'b0000;
        if (blink_phase) begin
            if (mode == ADJ_MIN) begin
                blank = 4'b1100;
            end else if (mode == ADJ_SEC) begin
                blank = 4'b0011;
            end
        end
    end

    seg7_scan u_scan (
        .clk       (clk),
        .reset     (reset),
        .tick_scan (tick_scan),
        .digits    ({min_bcd, sec_bcd}),
        .blank     (blank),
        .an        (an),
        .seg       (seg)
    );

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: integer minutes/seconds reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_stopwatch_core;

    localparam int MAX_MIN = 59;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_sec, tick_adj, tick_blink, tick_scan, pause_pulse;
    logic [1:0] adj_mode;
    logic [7:0] min_bcd, sec_bcd;
    logic       paused;
    logic [3:0] an;
    logic [6:0] seg;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference state in plain integers.
    int         m_min, m_sec, m_scan;
    bit         m_paused, m_blink;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    stopwatch_core #(.MAX_MIN(MAX_MIN)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_sec    (tick_sec),
        .tick_adj    (tick_adj),
        .tick_blink  (tick_blink),
        .tick_scan   (tick_scan),
        .pause_pulse (pause_pulse),
        .adj_mode    (adj_mode),
        .min_bcd     (min_bcd),
        .sec_bcd     (sec_bcd),
        .paused      (paused),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    // Lit segments a..g for each decimal digit, inverted for active-low pins.
    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] lit [10];
        lit = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        if (d < 0 || d > 9) return 7'h7F;
        return ~lit[d];
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derived from the pre-edge model state.
    always @(posedge clk) begin
        int em, nscan, t, dsel;
        int digs [4];
        logic [3:0] mask;
        if (reset) begin
            m_min <= 0; m_sec <= 0; m_paused <= 0; m_blink <= 0; m_scan <= 0;
            m_an <= 4'b1110; m_seg <= ref_seg(0);
        end else begin
            em = (adj_mode == 2'b11) ? 0 : int'(adj_mode);
            digs[0] = m_sec % 10; digs[1] = m_sec / 10;
            digs[2] = m_min % 10; digs[3] = m_min / 10;
            nscan = (m_scan + int'(tick_scan)) % 4;
            mask = 4'b0000;
            if (m_blink && em == 1) mask = 4'b1100;
            if (m_blink && em == 2) mask = 4'b0011;
            dsel = digs[nscan];
            m_scan <= nscan;
            m_an   <= ~(4'b0001 << nscan) | mask;
            m_seg  <= ref_seg(dsel);
            if (em == 0 && tick_sec && !m_paused) begin
                t = m_min * 60 + m_sec + 1;
                if (t >= (MAX_MIN + 1) * 60) t = 0;
                m_min <= t / 60;
                m_sec <= t % 60;
            end else if (em == 1 && tick_adj) begin
                m_min <= (m_min == MAX_MIN) ? 0 : m_min + 1;
            end else if (em == 2 && tick_adj) begin
                m_sec <= (m_sec + 1) % 60;
            end
            if (em == 0) m_blink <= 1'b0;
            else if (tick_blink) m_blink <= ~m_blink;
            if (pause_pulse) m_paused <= ~m_paused;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_min", min_bcd, to_bcd(m_min));
            check("model_sec", sec_bcd, to_bcd(m_sec));
            check("model_paused", {7'd0, paused}, {7'd0, m_paused});
            check("model_an", {4'd0, an}, {4'd0, m_an});
            check("model_seg", {1'b0, seg}, {1'b0, m_seg});
        end
    end

    // One cycle of stimulus, driven at negedge; returns at the next negedge.
    task automatic drive(input logic r, input logic [1:0] m, input logic ts, input logic ta,
                         input logic tb, input logic tsc, input logic pp);
        reset = r; adj_mode = m; tick_sec = ts; tick_adj = ta;
        tick_blink = tb; tick_scan = tsc; pause_pulse = pp;
        @(negedge clk);
        reset = 0; tick_sec = 0; tick_adj = 0; tick_blink = 0; tick_scan = 0; pause_pulse = 0;
    endtask

    task automatic adj_n(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) drive(0, m, 0, 1, 0, 0, 0);
    endtask

    task automatic sec_n(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 1, 0, 0, 0, 0);
    endtask

    task automatic check_time(input string name, input logic [7:0] mm, input logic [7:0] ss);
        check({name, "_min"}, min_bcd, mm);
        check({name, "_sec"}, sec_bcd, ss);
    endtask

    initial begin
        reset = 1; adj_mode = 2'b00;
        tick_sec = 0; tick_adj = 0; tick_blink = 0; tick_scan = 0; pause_pulse = 0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        reset = 0;

        check_time("reset", 8'h00, 8'h00);
        check("reset_paused", {7'd0, paused}, 8'h00);
        check("reset_an", {4'd0, an}, 8'h0E);
        check("reset_seg", {1'b0, seg}, 8'h01);

        // Rollover from 00:58 and from 59:59.
        adj_n(2'b10, 58);
        check_time("preload_0058", 8'h00, 8'h58);
        sec_n(2);
        check_time("roll_0100", 8'h01, 8'h00);
        adj_n(2'b01, 58);
        adj_n(2'b10, 59);
        check_time("preload_5959", 8'h59, 8'h59);
        sec_n(1);
        check_time("roll_0000", 8'h00, 8'h00);

        // Pause holds time; resume counts again.
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        sec_n(5);
        check_time("paused_hold", 8'h00, 8'h00);
        check("paused_high", {7'd0, paused}, 8'h01);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        sec_n(3);
        check_time("resume_3s", 8'h00, 8'h03);

        // Adjust modes.
        adj_n(2'b01, 58);
        adj_n(2'b10, 27);
        check_time("preload_5830", 8'h58, 8'h30);
        adj_n(2'b01, 3);
        check_time("adj_min_wrap", 8'h01, 8'h30);
        adj_n(2'b01, 4);
        adj_n(2'b10, 29);
        check_time("preload_0559", 8'h05, 8'h59);
        adj_n(2'b10, 1);
        check_time("adj_sec_nocarry", 8'h05, 8'h00);

        // Blink blanking of the minutes field at scan index 3.
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        drive(0, 2'b01, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4 && m_scan != 3; i++) drive(0, 2'b01, 0, 0, 0, 1, 0);
        check("blink_an_blank", {4'd0, an}, 8'h0F);
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        check("normal_an_idx3", {4'd0, an}, 8'h07);
        check("normal_seg_mintens", {1'b0, seg}, 8'h01);

        // Reset dominates an adjust tick.
        adj_n(2'b01, 7);
        adj_n(2'b10, 34);
        check_time("preload_1234", 8'h12, 8'h34);
        drive(0, 2'b10, 0, 0, 0, 0, 1);
        drive(1, 2'b10, 0, 1, 0, 0, 0);
        check_time("reset_mid_adj", 8'h00, 8'h00);
        check("reset_mid_adj_paused", {7'd0, paused}, 8'h00);
        check("reset_mid_adj_an", {4'd0, an}, 8'h0E);

        // Simultaneous events in normal mode.
        drive(0, 2'b00, 1, 0, 0, 0, 1);
        check_time("tick_with_pause", 8'h00, 8'h01);
        check("tick_with_pause_p", {7'd0, paused}, 8'h01);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        drive(0, 2'b00, 1, 1, 0, 0, 0);
        check_time("tick_sec_adj_normal", 8'h00, 8'h02);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 299) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 19) == 0));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
